// File: rtl/mult_bist_ctrl.sv
// BIST sequencer for the LFSR -> multiplier -> signature-analyzer datapath.
// Clears the TPG, steps the LFSR, aligns SA capture to the multiplier latency and checks the signature.
module mult_bist_ctrl #(
    parameter int unsigned NUM_PATTERNS = 256,
    parameter int unsigned MULT_LAT     = 2,
    parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] signature,
    output logic        tpg_clr,
    output logic        lfsr_en,
    output logic        sa_en,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] sig_captured
);

    // One counter serves both the pattern run and the drain, so size it for the larger.
    localparam int unsigned CNT_MAX = (NUM_PATTERNS > MULT_LAT) ? NUM_PATTERNS : MULT_LAT;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          tpg_clr_nxt;
    logic          lfsr_en_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          pass_nxt;
    logic [15:0]   sig_nxt;
    logic          abort_hit;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            tpg_clr      <= 1'b0;
            lfsr_en      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            sig_captured <= 16'h0000;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            tpg_clr      <= tpg_clr_nxt;
            lfsr_en      <= lfsr_en_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            pass         <= pass_nxt;
            sig_captured <= sig_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tpg_clr_nxt = 1'b0;
        lfsr_en_nxt = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = done;
        pass_nxt    = pass;
        sig_nxt     = sig_captured;
        abort_hit   = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    state_nxt   = S_INIT;
                    tpg_clr_nxt = 1'b1;
                    busy_nxt    = 1'b1;
                    done_nxt    = 1'b0;
                    pass_nxt    = 1'b0;
                    sig_nxt     = 16'h0000;
                end
            end
            S_INIT: begin
                state_nxt   = S_RUN;
                cnt_nxt     = CW'(NUM_PATTERNS);
                lfsr_en_nxt = 1'b1;
                busy_nxt    = 1'b1;
            end
            S_RUN: begin
                busy_nxt = 1'b1;
                if (cnt <= CW'(1)) begin
                    if (MULT_LAT == 0) begin
                        state_nxt = S_CAPTURE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_DRAIN;
                        cnt_nxt   = CW'(MULT_LAT);
                    end
                end else begin
                    cnt_nxt     = cnt - CW'(1);
                    lfsr_en_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                busy_nxt = 1'b1;
                if (cnt <= CW'(1)) begin
                    state_nxt = S_CAPTURE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_CAPTURE: begin
                state_nxt = S_DONE;
                done_nxt  = 1'b1;
                pass_nxt  = (signature == GOLDEN_SIG);
                sig_nxt   = signature;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Abort only cancels an active run; in IDLE/DONE it merely blocks start above.
        if (abort && (state == S_INIT || state == S_RUN ||
                      state == S_DRAIN || state == S_CAPTURE)) begin
            abort_hit   = 1'b1;
            state_nxt   = S_IDLE;
            cnt_nxt     = '0;
            tpg_clr_nxt = 1'b0;
            lfsr_en_nxt = 1'b0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b0;
            pass_nxt    = pass;
            sig_nxt     = sig_captured;
        end
    end

    // sa_en follows lfsr_en through MULT_LAT flops, matching the multiplier pipeline.
    generate
        if (MULT_LAT == 0) begin : g_no_delay
            assign sa_en = lfsr_en;
        end else begin : g_delay
            logic [MULT_LAT-1:0] dline;

            always_ff @(posedge clk) begin
                if (reset || tpg_clr || abort_hit) begin
                    dline <= '0;
                end else begin
                    dline[0] <= lfsr_en;
                    for (int i = 1; i < int'(MULT_LAT); i++) begin
                        dline[i] <= dline[i-1];
                    end
                end
            end

            assign sa_en = dline[MULT_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_mult_bist_ctrl.sv
// Self-checking bench for mult_bist_ctrl with a behavioural LFSR/multiplier/SA datapath
// and a scoreboard of expected end-of-run results.
module tb_mult_bist_ctrl;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int NA = 4;
    localparam int LA = 2;
    localparam int NC = 1;
    localparam int LC = 0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [15:0] prod(input logic [15:0] v);
        return {8'd0, v[15:8]} * {8'd0, v[7:0]};
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] p);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ p;
    endfunction

    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] s;
        logic [15:0] v;
        s = 16'h0000;
        v = SEED;
        for (int i = 0; i < n; i++) begin
            s = misr(s, prod(v));
            v = lfsr_step(v);
        end
        return s;
    endfunction

    localparam logic [15:0] SIG_A = model_sig(NA);
    localparam logic [15:0] SIG_C = model_sig(NC);

    logic        clk = 1'b0;
    logic        reset;
    logic        start_ab, abort_ab, start_c, abort_c;
    logic [15:0] sa_a, sa_c, lfsr_a, lfsr_c, p1_a, p2_a;

    logic        tpg_clr_a, lfsr_en_a, sa_en_a, busy_a, done_a, pass_a;
    logic        tpg_clr_b, lfsr_en_b, sa_en_b, busy_b, done_b, pass_b;
    logic        tpg_clr_c, lfsr_en_c, sa_en_c, busy_c, done_c, pass_c;
    logic [15:0] sig_a, sig_b, sig_c;

    int n_vec = 0;
    int n_err = 0;
    logic [16:0] q_a[$];
    logic [16:0] q_b[$];
    logic [16:0] q_c[$];

    always #5 clk = ~clk;

    mult_bist_ctrl #(.NUM_PATTERNS(NA), .MULT_LAT(LA), .GOLDEN_SIG(SIG_A)) dut_a (
        .clk(clk), .reset(reset), .start(start_ab), .abort(abort_ab), .signature(sa_a),
        .tpg_clr(tpg_clr_a), .lfsr_en(lfsr_en_a), .sa_en(sa_en_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .sig_captured(sig_a));

    mult_bist_ctrl #(.NUM_PATTERNS(NA), .MULT_LAT(LA), .GOLDEN_SIG(SIG_A ^ 16'h0001)) dut_b (
        .clk(clk), .reset(reset), .start(start_ab), .abort(abort_ab), .signature(sa_a),
        .tpg_clr(tpg_clr_b), .lfsr_en(lfsr_en_b), .sa_en(sa_en_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .sig_captured(sig_b));

    mult_bist_ctrl #(.NUM_PATTERNS(NC), .MULT_LAT(LC), .GOLDEN_SIG(SIG_C)) dut_c (
        .clk(clk), .reset(reset), .start(start_c), .abort(abort_c), .signature(sa_c),
        .tpg_clr(tpg_clr_c), .lfsr_en(lfsr_en_c), .sa_en(sa_en_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .sig_captured(sig_c));

    // Datapath model for the N=4, L=2 pair
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_a <= SEED;
            p1_a   <= 16'h0000;
            p2_a   <= 16'h0000;
            sa_a   <= 16'h0000;
        end else begin
            if (tpg_clr_a) lfsr_a <= SEED;
            else if (lfsr_en_a) lfsr_a <= lfsr_step(lfsr_a);
            p1_a <= prod(lfsr_a);
            p2_a <= p1_a;
            if (tpg_clr_a) sa_a <= 16'h0000;
            else if (sa_en_a) sa_a <= misr(sa_a, p2_a);
        end
    end

    // Datapath model for the N=1, L=0 instance
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_c <= SEED;
            sa_c   <= 16'h0000;
        end else begin
            if (tpg_clr_c) lfsr_c <= SEED;
            else if (lfsr_en_c) lfsr_c <= lfsr_step(lfsr_c);
            if (tpg_clr_c) sa_c <= 16'h0000;
            else if (sa_en_c) sa_c <= misr(sa_c, prod(lfsr_c));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {tpg_clr, lfsr_en, sa_en, busy, done} c cycles after the start edge
    function automatic logic [4:0] exp_ctrl(input int c, input int n, input int l, input int cut);
        if (cut >= 0 && c > cut) return 5'b00000;
        return {c == 0, (c >= 1) && (c <= n), (c >= 1 + l) && (c <= n + l),
                c <= n + l + 1, c >= n + l + 2};
    endfunction

    task automatic pop_check(input string tag, input logic [16:0] got, inout logic [16:0] q[$]);
        logic [16:0] e;
        if (q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(1), 32'(0));
        end else begin
            e = q.pop_front();
            check({tag, "_sig"}, 32'(got[16:1]), 32'(e[16:1]));
            check({tag, "_pass"}, 32'(got[0]), 32'(e[0]));
        end
    endtask

    // which: 0 = A/B pair, 1 = C. Event times are cycle indices; -1 disables.
    task automatic run(input int which, input int abort_at, input int restart_at,
                       input int reset_at, input bit expect_done);
        int n, l, cut;
        logic [4:0] got;
        n   = which ? NC : NA;
        l   = which ? LC : LA;
        cut = (abort_at >= 0) ? abort_at : reset_at;
        if (expect_done) begin
            if (which) q_c.push_back({SIG_C, 1'b1});
            else begin
                q_a.push_back({SIG_A, 1'b1});
                q_b.push_back({SIG_A, 1'b0});
            end
        end
        if (which) start_c = 1'b1; else start_ab = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= n + l + 3; c++) begin
            @(negedge clk);
            got = which ? {tpg_clr_c, lfsr_en_c, sa_en_c, busy_c, done_c}
                        : {tpg_clr_a, lfsr_en_a, sa_en_a, busy_a, done_a};
            check($sformatf("ctrl%0d_c%0d", which, c), 32'(got), 32'(exp_ctrl(c, n, l, cut)));
            if (expect_done && c == n + l + 2) begin
                if (which) pop_check("c", {sig_c, pass_c}, q_c);
                else begin
                    pop_check("a", {sig_a, pass_a}, q_a);
                    pop_check("b", {sig_b, pass_b}, q_b);
                    check("b_done", 32'(done_b), 32'(1));
                end
            end
            if (reset_at >= 0 && c == reset_at + 1)
                check("rst_mid_outs", 32'({sig_a, pass_a, busy_b, done_b}), 32'(0));
            if (which) begin
                start_c = (c == restart_at);
                abort_c = (c == abort_at);
            end else begin
                start_ab = (c == restart_at);
                abort_ab = (c == abort_at);
            end
            reset = (c == reset_at);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start_ab = 1'b0;
        abort_ab = 1'b0;
        start_c  = 1'b0;
        abort_c  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a", 32'({tpg_clr_a, lfsr_en_a, sa_en_a, busy_a, done_a, pass_a, sig_a}), 32'(0));
        check("reset_c", 32'({tpg_clr_c, lfsr_en_c, sa_en_c, busy_c, done_c, pass_c, sig_c}), 32'(0));
        reset = 1'b0;
        @(negedge clk);

        run(0, -1, -1, -1, 1'b1);
        run(0, -1,  2, -1, 1'b1);

        // start blocked by simultaneous abort while in DONE
        start_ab = 1'b1;
        abort_ab = 1'b1;
        @(negedge clk);
        start_ab = 1'b0;
        abort_ab = 1'b0;
        check("idle_abort_blocks", 32'({tpg_clr_a, busy_a, done_a, pass_a}), 32'(4'b0011));

        run(0,  2, -1, -1, 1'b0);
        run(0, -1, -1, -1, 1'b1);
        run(0, -1, -1,  5, 1'b0);
        run(0, -1, -1, -1, 1'b1);

        run(1, -1, -1, -1, 1'b1);
        run(1, -1, -1, -1, 1'b1);

        check("sb_drained", 32'(q_a.size() + q_b.size() + q_c.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
